// File: rtl/clint_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CLINT register port.
// One grant per transaction, with a watchdog that completes with an error if the slave never answers.
module clint_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_wmask,
   input  logic [31:0] m0_wdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_wmask,
   input  logic [31:0] m1_wdata,
   output logic        m1_ready,
   output logic [31:0] m_rdata,
   output logic        m_err,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [3:0]  s_wmask,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic        grant,
   output logic        busy
);

   // state   | meaning
   // --------+----------------------------------------------------------
   // ST_IDLE | no owner; arbitrate, ignore s_ready (stale from last txn)
   // ST_BUSY | r_grant owns the slave until ready, timeout or abort

   localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_grant;
   logic              w_grant_nxt;
   logic              r_last;
   logic              w_last_nxt;
   logic [WDOG_W-1:0] r_wdog;
   logic [WDOG_W-1:0] w_wdog_nxt;

   logic              w_req_valid;
   logic [31:0]       w_req_addr;
   logic [3:0]        w_req_wmask;
   logic [31:0]       w_req_wdata;
   logic              w_done;
   logic              w_expired;

   assign w_req_valid = r_grant ? m1_valid : m0_valid;
   assign w_req_addr  = r_grant ? m1_addr  : m0_addr;
   assign w_req_wmask = r_grant ? m1_wmask : m0_wmask;
   assign w_req_wdata = r_grant ? m1_wdata : m0_wdata;

   assign w_expired = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
         r_wdog  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_wdog  <= w_wdog_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_wdog_nxt  = r_wdog;
      w_done      = 1'b0;
      m_err       = 1'b0;
      m_rdata     = '0;
      s_valid     = 1'b0;
      s_addr      = '0;
      s_wmask     = '0;
      s_wdata     = '0;

      case (r_state)
         ST_IDLE: begin
            w_wdog_nxt = '0;
            if (m0_valid && m1_valid) begin
               w_grant_nxt = ~r_last;
               w_state_nxt = ST_BUSY;
            end else if (m0_valid) begin
               w_grant_nxt = 1'b0;
               w_state_nxt = ST_BUSY;
            end else if (m1_valid) begin
               w_grant_nxt = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end

         ST_BUSY: begin
            s_valid = w_req_valid;
            s_addr  = w_req_addr;
            s_wmask = w_req_wmask;
            s_wdata = w_req_wdata;
            // A dropped request abandons the slot silently; last stays so fairness is unaffected.
            if (!w_req_valid) begin
               w_state_nxt = ST_IDLE;
               w_wdog_nxt  = '0;
            end else if (s_ready) begin
               w_done      = 1'b1;
               m_rdata     = s_rdata;
               w_last_nxt  = r_grant;
               w_wdog_nxt  = '0;
               w_state_nxt = ST_IDLE;
            end else if (w_expired) begin
               w_done      = 1'b1;
               m_err       = 1'b1;
               w_last_nxt  = r_grant;
               w_wdog_nxt  = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_wdog_nxt = r_wdog + 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign m0_ready = w_done & ~r_grant;
   assign m1_ready = w_done &  r_grant;
   assign grant    = r_grant;
   assign busy     = (r_state == ST_BUSY);

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed bench for clint_bus_arbiter with a small CLINT model (registered ready, decoded 0x11xx_xxxx).
// TIMEOUT is set to 8 so the watchdog case runs in a few cycles.
module tb_clint_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wmask, m1_wmask;
   logic        m0_ready, m1_ready, m_err;
   logic [31:0] m_rdata;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wmask;
   logic        s_ready;
   logic        grant, busy;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          wr_cnt   = 0;
   int          wr_base;

   always #5 clk = ~clk;

   clint_bus_arbiter #(.TIMEOUT(8)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .m0_valid (m0_valid),
      .m0_addr  (m0_addr),
      .m0_wmask (m0_wmask),
      .m0_wdata (m0_wdata),
      .m0_ready (m0_ready),
      .m1_valid (m1_valid),
      .m1_addr  (m1_addr),
      .m1_wmask (m1_wmask),
      .m1_wdata (m1_wdata),
      .m1_ready (m1_ready),
      .m_rdata  (m_rdata),
      .m_err    (m_err),
      .s_valid  (s_valid),
      .s_addr   (s_addr),
      .s_wmask  (s_wmask),
      .s_wdata  (s_wdata),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .grant    (grant),
      .busy     (busy)
   );

   // CLINT model: undecoded addresses never answer
   assign s_rdata = (s_addr == 32'h1100_bff8) ? 32'h0000_1234 : (s_addr ^ 32'h5A5A_0000);

   always @(posedge clk) begin
      s_ready <= s_valid && (s_addr[31:24] == 8'h11);
      if (s_valid && s_ready && (s_wmask != 4'b0000))
         wr_cnt <= wr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_ready  = 1'b0;
      resetn   = 1'b0;
      m0_valid = 1'b0; m0_addr = '0; m0_wmask = '0; m0_wdata = '0;
      m1_valid = 1'b0; m1_addr = '0; m1_wmask = '0; m1_wdata = '0;
      repeat (3) nxt();

      @(negedge clk);
      chk("rst_busy",    busy,     0);
      chk("rst_grant",   grant,    0);
      chk("rst_s_valid", s_valid,  0);
      chk("rst_s_addr",  s_addr,   0);
      chk("rst_m0_rdy",  m0_ready, 0);
      chk("rst_m1_rdy",  m1_ready, 0);
      chk("rst_rdata",   m_rdata,  0);
      chk("rst_err",     m_err,    0);
      nxt();
      resetn = 1'b1;
      nxt();

      // single read, then a back-to-back read over the stale s_ready
      m0_valid = 1'b1; m0_addr = 32'h1100_bff8;
      @(negedge clk);
      chk("rd_t0_busy", busy, 0);
      chk("rd_t0_sval", s_valid, 0);
      nxt();
      @(negedge clk);
      chk("rd_t1_busy",  busy, 1);
      chk("rd_t1_grant", grant, 0);
      chk("rd_t1_sval",  s_valid, 1);
      chk("rd_t1_saddr", s_addr, 32'h1100_bff8);
      chk("rd_t1_m0rdy", m0_ready, 0);
      chk("rd_t1_rdata", m_rdata, 0);
      nxt();
      @(negedge clk);
      chk("rd_t2_m0rdy", m0_ready, 1);
      chk("rd_t2_rdata", m_rdata, 32'h0000_1234);
      chk("rd_t2_err",   m_err, 0);
      chk("rd_t2_m1rdy", m1_ready, 0);
      nxt();
      m0_addr = 32'h1100_0000;
      @(negedge clk);
      chk("stale_busy",  busy, 0);
      chk("stale_m0rdy", m0_ready, 0);
      chk("stale_sval",  s_valid, 0);
      nxt();
      @(negedge clk);
      chk("b2b_t4_m0rdy", m0_ready, 0);
      chk("b2b_t4_sval",  s_valid, 1);
      nxt();
      @(negedge clk);
      chk("b2b_t5_m0rdy", m0_ready, 1);
      chk("b2b_t5_rdata", m_rdata, 32'h4B5A_0000);
      nxt();
      m0_valid = 1'b0;
      @(negedge clk);
      chk("b2b_t6_m0rdy", m0_ready, 0);
      nxt();

      // contention from reset, both held: order 0,1,0,1 at T+2, T+5, T+8, T+11
      resetn = 1'b0;
      nxt();
      resetn = 1'b1;
      m0_valid = 1'b1; m0_addr = 32'h1100_0004;
      m1_valid = 1'b1; m1_addr = 32'h1100_0008;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("rr_m0rdy_%0d", k), m0_ready, (k == 2 || k == 8) ? 1 : 0);
         chk($sformatf("rr_m1rdy_%0d", k), m1_ready, (k == 5 || k == 11) ? 1 : 0);
         if (k % 3 == 1)
            chk($sformatf("rr_grant_%0d", k), grant, ((k / 3) % 2 == 1) ? 1 : 0);
         if (k == 5)
            chk("rr_m1_rdata", m_rdata, 32'h4B5A_0008);
         nxt();
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
      nxt();

      // m1 write, passed through unmodified, accepted once
      wr_base  = wr_cnt;
      m1_valid = 1'b1; m1_addr = 32'h1100_4000; m1_wmask = 4'b0011; m1_wdata = 32'hDEAD_BEEF;
      nxt();
      @(negedge clk);
      chk("wr_grant", grant, 1);
      chk("wr_saddr", s_addr, 32'h1100_4000);
      chk("wr_wmask", s_wmask, 4'b0011);
      chk("wr_wdata", s_wdata, 32'hDEAD_BEEF);
      chk("wr_t1_m1rdy", m1_ready, 0);
      nxt();
      @(negedge clk);
      chk("wr_t2_m1rdy", m1_ready, 1);
      chk("wr_t2_m0rdy", m0_ready, 0);
      nxt();
      m1_valid = 1'b0; m1_wmask = 4'b0000; m1_wdata = '0;
      @(negedge clk);
      chk("wr_t3_m1rdy", m1_ready, 0);
      chk("wr_t3_sval",  s_valid, 0);
      nxt();
      nxt();
      chk("wr_accepts", wr_cnt - wr_base, 1);

      // watchdog: m0 to an undecoded address, m1 waiting
      m0_valid = 1'b1; m0_addr = 32'h2000_0000;
      m1_valid = 1'b1; m1_addr = 32'h1100_0040;
      nxt();
      @(negedge clk);
      chk("to_grant", grant, 0);
      repeat (6) nxt();
      @(negedge clk);
      chk("to_c7_m0rdy", m0_ready, 0);
      chk("to_c7_err",   m_err, 0);
      nxt();
      @(negedge clk);
      chk("to_c8_m0rdy", m0_ready, 1);
      chk("to_c8_err",   m_err, 1);
      chk("to_c8_rdata", m_rdata, 0);
      chk("to_c8_m1rdy", m1_ready, 0);
      nxt();
      m0_valid = 1'b0;
      @(negedge clk);
      chk("to_c9_busy", busy, 0);
      nxt();
      @(negedge clk);
      chk("to_c10_busy",  busy, 1);
      chk("to_c10_grant", grant, 1);
      chk("to_c10_m1rdy", m1_ready, 0);
      nxt();
      @(negedge clk);
      chk("to_c11_m1rdy", m1_ready, 1);
      chk("to_c11_err",   m_err, 0);
      chk("to_c11_rdata", m_rdata, 32'h4B5A_0040);
      nxt();
      m1_valid = 1'b0;
      nxt();

      // reset in the middle of an m1 transaction
      m1_valid = 1'b1; m1_addr = 32'h1100_0050;
      nxt();
      @(negedge clk);
      chk("mr_busy",  busy, 1);
      chk("mr_grant", grant, 1);
      #1;
      resetn = 1'b0; m1_valid = 1'b0;
      nxt();
      resetn = 1'b1;
      @(negedge clk);
      chk("mr_after_busy",  busy, 0);
      chk("mr_after_grant", grant, 0);
      chk("mr_after_m1rdy", m1_ready, 0);
      chk("mr_after_m0rdy", m0_ready, 0);
      nxt();

      // recovery read by m0 (last becomes 0)
      m0_valid = 1'b1; m0_addr = 32'h1100_0010;
      nxt();
      nxt();
      @(negedge clk);
      chk("rec_m0rdy", m0_ready, 1);
      chk("rec_rdata", m_rdata, 32'h4B5A_0010);
      chk("rec_err",   m_err, 0);
      nxt();
      m0_valid = 1'b0;
      nxt();

      // abort: m1 drops valid while granted
      m1_valid = 1'b1; m1_addr = 32'h1100_0020;
      nxt();
      @(negedge clk);
      chk("ab_busy",  busy, 1);
      chk("ab_grant", grant, 1);
      nxt();
      m1_valid = 1'b0;
      @(negedge clk);
      chk("ab_m1rdy", m1_ready, 0);
      chk("ab_m0rdy", m0_ready, 0);
      chk("ab_sval",  s_valid, 0);
      nxt();
      @(negedge clk);
      chk("ab_idle", busy, 0);
      nxt();

      // abort left last at 0, so contention now favours m1
      m0_valid = 1'b1; m0_addr = 32'h1100_0030;
      m1_valid = 1'b1; m1_addr = 32'h1100_0034;
      nxt();
      @(negedge clk);
      chk("post_ab_grant", grant, 1);
      nxt();
      @(negedge clk);
      chk("post_ab_m1rdy", m1_ready, 1);
      chk("post_ab_m0rdy", m0_ready, 0);
      chk("post_ab_rdata", m_rdata, 32'h4B5A_0034);
      nxt();
      m0_valid = 1'b0; m1_valid = 1'b0;
      nxt();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
